gf180mcu_osu_sc_gp12t3v3__tiebank: RTL and testbench

GF180MCU_OSU_SC_GP12T3V3__TIEBANK -- requirements
Module: gf180mcu_osu_sc_gp12t3v3__tiebank

---
 rtl/gf180mcu_osu_sc_gp12t3v3__tiebank.sv | 78 +++++++
 tb/tb_gf180mcu_osu_sc_gp12t3v3__tiebank.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_osu_sc_gp12t3v3__tiebank.sv
// Bank of registered tie-off constants loaded through a serial shadow register.
// A full shadow load is copied to Y on UPD; LOCK freezes the whole bank until reset.
module gf180mcu_osu_sc_gp12t3v3__tiebank #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             SE,
    input  logic             SI,
    input  logic             UPD,
    input  logic             LOCK,
    output logic [WIDTH-1:0] Y,
    output logic             SO,
    output logic             FULL,
    output logic             LOCKED
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] sh_q, sh_d, sh_shift;
    logic [WIDTH-1:0] y_q, y_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             locked_q, locked_d;
    logic             full;

    assign full = (cnt_q == CW'(WIDTH));

    // Shift toward bit 0; written as a loop so WIDTH=1 needs no empty slice.
    always_comb begin
        sh_shift = sh_q;
        for (int i = 0; i < WIDTH - 1; i++) begin
            sh_shift[i] = sh_q[i+1];
        end
        sh_shift[WIDTH-1] = SI;
    end

    always_comb begin
        sh_d     = sh_q;
        y_d      = y_q;
        cnt_d    = cnt_q;
        locked_d = locked_q | LOCK;
        // UPD wins over SE even when it is ignored for lack of a full load.
        if (!locked_q) begin
            if (UPD) begin
                if (full) begin
                    y_d   = sh_q;
                    cnt_d = '0;
                end
            end else if (SE) begin
                sh_d = sh_shift;
                if (!full) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            sh_q     <= RESET_VAL;
            y_q      <= RESET_VAL;
            cnt_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            sh_q     <= sh_d;
            y_q      <= y_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
        end
    end

    assign Y      = y_q;
    assign SO     = sh_q[0];
    assign FULL   = full;
    assign LOCKED = locked_q;

endmodule

// File: tb/tb_gf180mcu_osu_sc_gp12t3v3__tiebank.sv
// Directed self-checking bench for the tie bank at WIDTH=8, RESET_VAL=0.
module tb_gf180mcu_osu_sc_gp12t3v3__tiebank;

    logic       CLK = 1'b0;
    logic       R = 1'b1;
    logic       SE = 1'b0;
    logic       SI = 1'b0;
    logic       UPD = 1'b0;
    logic       LOCK = 1'b0;
    logic [7:0] Y;
    logic       SO, FULL, LOCKED;

    int errors = 0;
    int checks = 0;

    gf180mcu_osu_sc_gp12t3v3__tiebank #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .CLK(CLK), .R(R), .SE(SE), .SI(SI), .UPD(UPD), .LOCK(LOCK),
        .Y(Y), .SO(SO), .FULL(FULL), .LOCKED(LOCKED)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic shift_bits(input logic [7:0] v, input int start, input int n);
        for (int i = 0; i < n; i++) begin
            SE = 1'b1;
            SI = v[start+i];
            tick();
        end
        SE = 1'b0;
        SI = 1'b0;
    endtask

    task automatic pulse_upd();
        UPD = 1'b1;
        tick();
        UPD = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        R = 1'b1;
        #2;
        R = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        if (Y !== 8'h00) begin errors++; $display("FAIL reset_y: got %h exp 00", Y); end
        checks++;
        if (SO !== 1'b0) begin errors++; $display("FAIL reset_so: got %b exp 0", SO); end
        checks++;
        if (FULL !== 1'b0) begin errors++; $display("FAIL reset_full: got %b exp 0", FULL); end
        checks++;
        if (LOCKED !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b exp 0", LOCKED); end
        checks++;
        @(negedge CLK);
        R = 1'b0;
    endtask

    task automatic test_full_update();
        shift_bits(8'hA5, 0, 7);
        if (FULL !== 1'b0) begin errors++; $display("FAIL full_after7: got %b exp 0", FULL); end
        checks++;
        shift_bits(8'hA5, 7, 1);
        if (FULL !== 1'b1) begin errors++; $display("FAIL full_after8: got %b exp 1", FULL); end
        checks++;
        if (Y !== 8'h00) begin errors++; $display("FAIL y_before_upd: got %h exp 00", Y); end
        checks++;
        if (SO !== 1'b1) begin errors++; $display("FAIL so_first_bit: got %b exp 1", SO); end
        checks++;
        pulse_upd();
        if (Y !== 8'hA5) begin errors++; $display("FAIL upd_y: got %h exp a5", Y); end
        checks++;
        if (FULL !== 1'b0) begin errors++; $display("FAIL upd_full_clear: got %b exp 0", FULL); end
        checks++;
    endtask

    task automatic test_partial();
        pulse_reset();
        shift_bits(8'h3C, 0, 5);
        pulse_upd();
        if (Y !== 8'h00) begin errors++; $display("FAIL partial_y: got %h exp 00", Y); end
        checks++;
        if (FULL !== 1'b0) begin errors++; $display("FAIL partial_full: got %b exp 0", FULL); end
        checks++;
        shift_bits(8'h3C, 5, 2);
        if (FULL !== 1'b0) begin errors++; $display("FAIL partial_cnt7: got %b exp 0", FULL); end
        checks++;
        shift_bits(8'h3C, 7, 1);
        if (FULL !== 1'b1) begin errors++; $display("FAIL partial_cnt8: got %b exp 1", FULL); end
        checks++;
        pulse_upd();
        if (Y !== 8'h3C) begin errors++; $display("FAIL partial_final_y: got %h exp 3c", Y); end
        checks++;
    endtask

    task automatic test_upd_priority();
        shift_bits(8'h69, 0, 8);
        SE = 1'b1;
        SI = 1'b0;
        UPD = 1'b1;
        tick();
        SE = 1'b0;
        UPD = 1'b0;
        if (Y !== 8'h69) begin errors++; $display("FAIL prio_y: got %h exp 69", Y); end
        checks++;
        if (SO !== 1'b1) begin errors++; $display("FAIL prio_no_shift: got %b exp 1", SO); end
        checks++;
        if (FULL !== 1'b0) begin errors++; $display("FAIL prio_full: got %b exp 0", FULL); end
        checks++;
    endtask

    task automatic test_lock();
        pulse_reset();
        shift_bits(8'hA5, 0, 8);
        pulse_upd();
        LOCK = 1'b1;
        tick();
        LOCK = 1'b0;
        if (LOCKED !== 1'b1) begin errors++; $display("FAIL lock_set: got %b exp 1", LOCKED); end
        checks++;
        shift_bits(8'hFF, 0, 1);
        if (SO !== 1'b1) begin errors++; $display("FAIL lock_so_frozen: got %b exp 1", SO); end
        checks++;
        shift_bits(8'hFF, 1, 7);
        if (FULL !== 1'b0) begin errors++; $display("FAIL lock_full_frozen: got %b exp 0", FULL); end
        checks++;
        pulse_upd();
        if (Y !== 8'hA5) begin errors++; $display("FAIL lock_y_frozen: got %h exp a5", Y); end
        checks++;
        if (LOCKED !== 1'b1) begin errors++; $display("FAIL lock_sticky: got %b exp 1", LOCKED); end
        checks++;
        pulse_reset();
        #1;
        if (Y !== 8'h00) begin errors++; $display("FAIL lock_reset_y: got %h exp 00", Y); end
        checks++;
        if (LOCKED !== 1'b0) begin errors++; $display("FAIL lock_reset_locked: got %b exp 0", LOCKED); end
        checks++;
    endtask

    task automatic test_lock_with_upd();
        shift_bits(8'h5A, 0, 8);
        UPD = 1'b1;
        LOCK = 1'b1;
        tick();
        UPD = 1'b0;
        LOCK = 1'b0;
        if (Y !== 8'h5A) begin errors++; $display("FAIL lockupd_y: got %h exp 5a", Y); end
        checks++;
        if (LOCKED !== 1'b1) begin errors++; $display("FAIL lockupd_locked: got %b exp 1", LOCKED); end
        checks++;
    endtask

    task automatic test_async_reset();
        pulse_reset();
        shift_bits(8'hA5, 0, 8);
        pulse_upd();
        shift_bits(8'hFF, 0, 3);
        // SH is now 8'hF4 with Y=A5, FULL=0, SO=0; one more shift of 1 makes SO=0, use SI=1 x4.
        shift_bits(8'hFF, 3, 1);
        if (Y !== 8'hA5) begin errors++; $display("FAIL pre_async_y: got %h exp a5", Y); end
        checks++;
        #2;
        R = 1'b1;
        #1;
        if (Y !== 8'h00) begin errors++; $display("FAIL async_y: got %h exp 00", Y); end
        checks++;
        if (SO !== 1'b0 || FULL !== 1'b0 || LOCKED !== 1'b0) begin
            errors++;
            $display("FAIL async_flags: got so=%b full=%b locked=%b exp 0 0 0", SO, FULL, LOCKED);
        end
        checks++;
        R = 1'b0;
        shift_bits(8'hC3, 0, 8);
        if (FULL !== 1'b1) begin errors++; $display("FAIL post_reset_full: got %b exp 1", FULL); end
        checks++;
        pulse_upd();
        if (Y !== 8'hC3) begin errors++; $display("FAIL post_reset_y: got %h exp c3", Y); end
        checks++;
    endtask

    initial begin
        test_reset();
        test_full_update();
        test_partial();
        test_upd_priority();
        test_lock();
        test_lock_with_upd();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
